// File: rtl/jpeg_pkg.sv
// Shared JPEG block types and constants. The zigzag LUT is compiled only when
// QUANT_ZIGZAG_EN is defined.
package jpeg_pkg;

   localparam int unsigned BLK_N  = 64;
   localparam int unsigned COEF_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } seq_state_t;

`ifdef QUANT_ZIGZAG_EN
   // Raster index -> position in the zigzag scan.
   localparam logic [5:0] ZZ_LUT [64] = '{
       6'd0,  6'd1,  6'd5,  6'd6,  6'd14, 6'd15, 6'd27, 6'd28,
       6'd2,  6'd4,  6'd7,  6'd13, 6'd16, 6'd26, 6'd29, 6'd42,
       6'd3,  6'd8,  6'd12, 6'd17, 6'd25, 6'd30, 6'd41, 6'd43,
       6'd9,  6'd11, 6'd18, 6'd24, 6'd31, 6'd40, 6'd44, 6'd53,
       6'd10, 6'd19, 6'd23, 6'd32, 6'd39, 6'd45, 6'd52, 6'd54,
       6'd20, 6'd22, 6'd33, 6'd38, 6'd46, 6'd51, 6'd55, 6'd60,
       6'd21, 6'd34, 6'd37, 6'd47, 6'd50, 6'd56, 6'd59, 6'd61,
       6'd35, 6'd36, 6'd48, 6'd49, 6'd57, 6'd58, 6'd62, 6'd63
   };
`endif

endpackage

// File: rtl/quant_block_seq_result_fifo.sv
// Synchronous FIFO holding converter results until the downstream consumer
// accepts them; head word is visible the cycle after it is written.
module result_fifo #(
   parameter  int unsigned DEPTH = 4,
   parameter  int unsigned W     = 8,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [W-1:0]     din,
   input  logic             pop,
   output logic [W-1:0]     dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // NOTE: every variable gets a default before any branch so no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: non-blocking assignments for all clocked state so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; pointers and count define validity, and readers gate on empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/quant_block_seq.sv
// Streams one 8x8 block of float coefficients through the shared float-to-int8
// converter and delivers results under valid/ready. QUANT_ZIGZAG_EN remaps dst_addr.
module quant_block_seq
   import jpeg_pkg::*;
#(
   parameter int unsigned COEF_W     = 32,
   parameter int unsigned ADDR_W     = 6,
   parameter int unsigned CONV_LAT   = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              src_rd,
   output logic [ADDR_W-1:0] src_addr,
   input  logic [COEF_W-1:0] src_data,
   output logic [COEF_W-1:0] cv_din,
   output logic              cv_din_valid,
   input  logic [7:0]        cv_dout,
   input  logic              cv_dout_valid,
   output logic              dst_valid,
   input  logic              dst_ready,
   output logic [ADDR_W-1:0] dst_addr,
   output logic [7:0]        dst_data
);

   // Every in-flight read must find room in the FIFO; an undersized depth is raised.
   localparam int unsigned EFF_DEPTH = (FIFO_DEPTH >= CONV_LAT + 3) ? FIFO_DEPTH : CONV_LAT + 3;
   localparam int unsigned CNT_W     = ADDR_W + 1;
   localparam int unsigned FCNT_W    = $clog2(EFF_DEPTH + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BLK_N - 1);

   seq_state_t        state_q, state_d;
   logic [CNT_W-1:0]  iss_cnt_q, iss_cnt_d;
   logic [CNT_W-1:0]  xfer_cnt_q, xfer_cnt_d;
   logic [ADDR_W-1:0] src_addr_q, src_addr_d;
   logic              err_q, err_d;
   logic              cv_din_valid_q, cv_din_valid_d;

   logic [CNT_W-1:0]  outstanding;
   logic              issue_ok, start_ok, xfer, push;
   logic              fifo_full, fifo_empty;
   logic [7:0]        fifo_dout;
   logic [FCNT_W-1:0] fifo_count;

   assign outstanding = iss_cnt_q - xfer_cnt_q;
   assign start_ok    = (state_q == IDLE) && start;
   assign xfer        = dst_valid && dst_ready;
   assign push        = cv_dout_valid && (state_q != IDLE);
   assign issue_ok    = (state_q == RUN) &&
                        ((outstanding < CNT_W'(EFF_DEPTH)) ||
                         ((outstanding == CNT_W'(EFF_DEPTH)) && xfer));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         iss_cnt_q      <= '0;
         xfer_cnt_q     <= '0;
         src_addr_q     <= '0;
         err_q          <= 1'b0;
         cv_din_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         iss_cnt_q      <= iss_cnt_d;
         xfer_cnt_q     <= xfer_cnt_d;
         src_addr_q     <= src_addr_d;
         err_q          <= err_d;
         cv_din_valid_q <= cv_din_valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (issue_ok && (src_addr_q == LAST_ADDR)) state_d = DRAIN;
         DRAIN:   if (xfer_cnt_d == CNT_W'(BLK_N)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      iss_cnt_d      = iss_cnt_q;
      xfer_cnt_d     = xfer_cnt_q;
      src_addr_d     = src_addr_q;
      err_d          = err_q;
      cv_din_valid_d = issue_ok;
      if (start_ok) begin
         iss_cnt_d  = '0;
         xfer_cnt_d = '0;
         src_addr_d = '0;
         err_d      = 1'b0;
      end else begin
         if (issue_ok) begin
            iss_cnt_d = iss_cnt_q + CNT_W'(1);
            // The last read leaves the index parked on 63 rather than wrapping.
            if (src_addr_q != LAST_ADDR) src_addr_d = src_addr_q + ADDR_W'(1);
         end
         if (xfer) xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
         if (push && fifo_full) err_d = 1'b1;
      end
   end

   always_comb begin
      busy         = (state_q == RUN) || (state_q == DRAIN);
      done         = (state_q == DONE);
      err          = err_q;
      src_rd       = issue_ok;
      src_addr     = src_addr_q;
      cv_din       = src_data;
      cv_din_valid = cv_din_valid_q;
      dst_valid    = (fifo_count != '0);
      dst_data     = fifo_empty ? 8'h00 : fifo_dout;
`ifdef QUANT_ZIGZAG_EN
      dst_addr     = ADDR_W'(ZZ_LUT[xfer_cnt_q[5:0]]);
`else
      dst_addr     = xfer_cnt_q[ADDR_W-1:0];
`endif
   end

   result_fifo #(
      .DEPTH (EFF_DEPTH),
      .W     (8)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (cv_dout),
      .pop   (xfer),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_quant_block_seq.sv
// Directed bench for quant_block_seq with a block-buffer model and a one-cycle
// float-to-int8 converter model; zigzag expectations follow QUANT_ZIGZAG_EN.
module tb_quant_block_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        busy, done, err, src_rd;
   logic [5:0]  src_addr;
   logic [31:0] src_data = '0;
   logic [31:0] cv_din;
   logic        cv_din_valid;
   logic [7:0]  cv_dout = '0;
   logic        cv_dout_valid = 1'b0;
   logic        dst_valid;
   logic        dst_ready = 1'b0;
   logic [5:0]  dst_addr;
   logic [7:0]  dst_data;

   quant_block_seq dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .src_rd        (src_rd),
      .src_addr      (src_addr),
      .src_data      (src_data),
      .cv_din        (cv_din),
      .cv_din_valid  (cv_din_valid),
      .cv_dout       (cv_dout),
      .cv_dout_valid (cv_dout_valid),
      .dst_valid     (dst_valid),
      .dst_ready     (dst_ready),
      .dst_addr      (dst_addr),
      .dst_data      (dst_data)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int c0 = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] i2f(input int v);
      logic [31:0] a;
      int p;
      logic [31:0] m;
      if (v == 0) return 32'h0;
      a = (v < 0) ? 32'(-v) : 32'(v);
      p = 0;
      for (int i = 0; i < 31; i++) if (a[i]) p = i;
      m = (a << (23 - p)) & 32'h007f_ffff;
      return {(v < 0), 8'(127 + p), m[22:0]};
   endfunction

   function automatic logic [7:0] f2i8(input logic [31:0] b);
      int e;
      int mag;
      logic [23:0] m;
      e = int'(b[30:23]) - 127;
      if (e < 0) return 8'h00;
      if (e > 6) return b[31] ? 8'h80 : 8'h7f;
      m = {1'b1, b[22:0]};
      mag = int'(m >> (23 - e));
      return b[31] ? 8'(-mag) : 8'(mag);
   endfunction

   // Block buffer and converter models.
   logic [31:0] src_mem [64];
   logic        inj = 1'b0;
   logic [7:0]  inj_data = '0;

   always @(posedge clk) if (src_rd) src_data <= src_mem[src_addr];

   always @(posedge clk) begin
      cv_dout_valid <= cv_din_valid | inj;
      cv_dout       <= inj ? inj_data : f2i8(cv_din);
   end

   // dst_ready patterns, relative to the cycle of the last start.
   int rmode = 0;
   always @(posedge clk) begin
      #1;
      case (rmode)
         0:       dst_ready = 1'b1;
         1:       dst_ready = !(((cyc - c0) >= 5) && ((cyc - c0) <= 20));
         2:       dst_ready = (((cyc - c0) % 2) == 0);
         default: dst_ready = 1'b0;
      endcase
   end

   // Monitor: transfer log, done/busy bookkeeping and stall stability.
   logic [5:0] log_addr [1024];
   logic [7:0] log_data [1024];
   int         log_cyc  [1024];
   int  n_log = 0, rd_cnt = 0, done_cnt = 0, done_cyc = -1;
   int  busy_first = -1, busy_last = -1, busy_cnt = 0;
   int  stab_n = 0, stab_err = 0;
   int  mrel;
   logic busy_prev = 1'b0, hold_v = 1'b0;
   logic [5:0] hold_a;
   logic [7:0] hold_d;

   always @(negedge clk) begin
      mrel = cyc - c0;
      if (!rst) begin
         if (src_rd) rd_cnt++;
         if (busy && !busy_prev) busy_first = mrel;
         if (busy) begin
            busy_last = mrel;
            busy_cnt++;
         end
         if (done) begin
            done_cnt++;
            done_cyc = mrel;
         end
         if (hold_v) begin
            stab_n++;
            if (!(dst_valid && dst_addr == hold_a && dst_data == hold_d)) stab_err++;
         end
         if (dst_valid && dst_ready && n_log < 1024) begin
            log_addr[n_log] = dst_addr;
            log_data[n_log] = dst_data;
            log_cyc[n_log]  = mrel;
            n_log++;
         end
      end
      hold_v    = !rst && dst_valid && !dst_ready;
      hold_a    = dst_addr;
      hold_d    = dst_data;
      busy_prev = busy;
   end

   typedef struct {
      logic [31:0] src;
      logic [5:0]  addr;
      logic [7:0]  data;
      int          cyc;
   } vec_t;

   vec_t vt [64];
   int zz_scan [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63 };
   int zz_pos [64];

   int n0, rd0, done0, busy0, stab0, stabn0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_busy"},         busy, 0);
      check({tag, "_done"},         done, 0);
      check({tag, "_err"},          err, 0);
      check({tag, "_src_rd"},       src_rd, 0);
      check({tag, "_src_addr"},     src_addr, 0);
      check({tag, "_cv_din_valid"}, cv_din_valid, 0);
      check({tag, "_dst_valid"},    dst_valid, 0);
      check({tag, "_dst_addr"},     dst_addr, 0);
      check({tag, "_dst_data"},     dst_data, 0);
   endtask

   task automatic start_job();
      @(negedge clk);
      c0     = cyc;
      n0     = n_log;
      rd0    = rd_cnt;
      done0  = done_cnt;
      busy0  = busy_cnt;
      stab0  = stab_err;
      stabn0 = stab_n;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({name, "_done_reached"}, done, 1);
   endtask

   task automatic verify(input string name, input int base, input bit chk_cyc);
      check({name, "_count"}, n_log - base, 64);
      for (int k = 0; k < 64; k++) begin
         check($sformatf("%s_addr[%0d]", name, k), log_addr[base + k], vt[k].addr);
         check($sformatf("%s_data[%0d]", name, k), log_data[base + k], vt[k].data);
         if (chk_cyc) check($sformatf("%s_cyc[%0d]", name, k), log_cyc[base + k], vt[k].cyc);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) zz_pos[zz_scan[i]] = i;
      for (int k = 0; k < 64; k++) begin
         vt[k].src  = i2f(k - 32);
         vt[k].data = 8'(k - 32);
`ifdef QUANT_ZIGZAG_EN
         vt[k].addr = 6'(zz_pos[k]);
`else
         vt[k].addr = 6'(k);
`endif
         vt[k].cyc  = 4 + k;
         src_mem[k] = vt[k].src;
      end

      // Reset state
      repeat (2) @(negedge clk);
      check_outputs_zero("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Basic block, full throughput
      rmode = 0;
      start_job();
      wait_done("basic", 200);
      repeat (3) @(negedge clk);
      check("basic_done_once",  done_cnt - done0, 1);
      check("basic_done_cycle", done_cyc, 68);
      check("basic_busy_first", busy_first, 1);
      check("basic_busy_last",  busy_last, 67);
      check("basic_busy_cnt",   busy_cnt - busy0, 67);
      check("basic_err",        err, 0);
      verify("basic", n0, 1'b1);
      check("basic_first_data", log_data[n0], 8'd224);
`ifdef QUANT_ZIGZAG_EN
      check("zz_r8_addr", log_addr[n0 + 8], 2);
      check("zz_r8_data", log_data[n0 + 8], 8'd232);
      check("zz_r2_addr", log_addr[n0 + 2], 5);
`else
      check("raster_r8_addr", log_addr[n0 + 8], 8);
`endif

      // Backpressure window
      rmode = 1;
      start_job();
      repeat (19) @(negedge clk);
      #2;
      check("bp_stalled_rd",   src_rd, 0);
      check("bp_outstanding",  (rd_cnt - rd0) - (n_log - n0), 4);
      wait_done("bp", 300);
      repeat (2) @(negedge clk);
      check("bp_err",          err, 0);
      check("bp_done_once",    done_cnt - done0, 1);
      check("bp_stable",       stab_err - stab0, 0);
      check("bp_stalls_seen",  (stab_n - stabn0) > 0, 1);
      verify("bp", n0, 1'b0);

      // Alternating ready; start pulses while busy and in DONE are ignored
      rmode = 2;
      start_job();
      repeat (8) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("alt", 400);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("alt_start_in_done_busy", busy, 0);
      @(negedge clk);
      check("alt_idle_busy", busy, 0);
      check("alt_idle_done", done, 0);
      repeat (2) @(negedge clk);
      check("alt_done_once",   done_cnt - done0, 1);
      check("alt_stable",      stab_err - stab0, 0);
      check("alt_stalls_seen", (stab_n - stabn0) > 0, 1);
      verify("alt", n0, 1'b0);

      // Reset mid-job, then stale converter output, then a clean block
      rmode = 0;
      start_job();
      repeat (29) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_outputs_zero("midrst");
      rst = 1'b0;
      n0 = n_log;
      inj_data = 8'h55;
      inj = 1'b1;
      @(negedge clk);
      inj = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("stale_dst_valid[%0d]", i), dst_valid, 0);
      end
      check("stale_no_writes", n_log - n0, 0);
      start_job();
      wait_done("postrst", 200);
      repeat (2) @(negedge clk);
      check("postrst_done_cycle", done_cyc, 68);
      verify("postrst", n0, 1'b1);

      // Overflow: extra result into a full FIFO
      rmode = 3;
      start_job();
      repeat (11) @(negedge clk);
      check("ovf_pre_err",  err, 0);
      check("ovf_stalled",  src_rd, 0);
      inj_data = 8'hAA;
      inj = 1'b1;
      @(negedge clk);
      inj = 1'b0;
      @(negedge clk);
      check("ovf_err_set", err, 1);
      rmode = 0;
      wait_done("ovf", 300);
      repeat (3) @(negedge clk);
      check("ovf_err_sticky", err, 1);
      verify("ovf", n0, 1'b0);
      start_job();
      check("ovf_err_cleared", err, 0);
      wait_done("ovf_next", 200);
      repeat (2) @(negedge clk);
      check("ovf_next_err", err, 0);
      verify("ovf_next", n0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
      $fatal(1);
   end

endmodule
